// File: rtl/music_sequencer.sv
// Song playback scheduler: decodes key presses into play/pause/stop/speed/loop
// commands and steps the music ROM beat address at a divisor-counted tempo.
module music_sequencer #(
  parameter int ADDR_W     = 9,
  parameter int SONG_LEN   = 512,
  parameter int NORMAL_DIV = 4194304,
  parameter int FAST_DIV   = 2097152
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [511:0]      key_down,
  input  logic [8:0]        last_change,
  input  logic              key_valid,
  output logic [ADDR_W-1:0] beat_addr,
  output logic              beat_tick,
  output logic              playing,
  output logic              paused,
  output logic              speed_fast,
  output logic              loop_en,
  output logic              song_done
);
  localparam int CNT_W = (NORMAL_DIV > 1) ? $clog2(NORMAL_DIV) : 1;
  localparam logic [CNT_W-1:0]  NORM_M1 = CNT_W'(NORMAL_DIV - 1);
  localparam logic [CNT_W-1:0]  FAST_M1 = CNT_W'(FAST_DIV - 1);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(SONG_LEN - 1);

  localparam logic [8:0] K_Z = 9'h01A;
  localparam logic [8:0] K_X = 9'h022;
  localparam logic [8:0] K_P = 9'h04D;
  localparam logic [8:0] K_S = 9'h01B;
  localparam logic [8:0] K_L = 9'h04B;

  typedef enum logic [1:0] {ST_STOP, ST_PLAY, ST_PAUSE} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_tick, r_done, r_playing, r_paused, r_fast, r_loop;

  logic              w_press, w_cmd_s, w_cmd_p, w_term;
  logic [CNT_W-1:0]  w_div_m1;

  assign w_press  = key_valid && key_down[last_change];
  assign w_cmd_s  = w_press && (last_change == K_S);
  assign w_cmd_p  = w_press && (last_change == K_P);
  assign w_div_m1 = r_fast ? FAST_M1 : NORM_M1;
  // >= rather than == so a mid-beat switch to fast past the new limit ticks at once
  assign w_term   = (r_cnt >= w_div_m1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_STOP;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_tick    <= 1'b0;
      r_done    <= 1'b0;
      r_playing <= 1'b0;
      r_paused  <= 1'b0;
      r_fast    <= 1'b0;
      r_loop    <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_done <= 1'b0;

      if (w_press && last_change == K_Z) r_fast <= 1'b0;
      if (w_press && last_change == K_X) r_fast <= 1'b1;
      if (w_press && last_change == K_L) r_loop <= ~r_loop;

      if (w_cmd_s) begin
        r_state   <= ST_STOP;
        r_playing <= 1'b0;
        r_paused  <= 1'b0;
        r_addr    <= '0;
        r_cnt     <= '0;
      end else if (w_cmd_p) begin
        case (r_state)
          ST_STOP: begin
            r_state   <= ST_PLAY;
            r_playing <= 1'b1;
            r_paused  <= 1'b0;
            r_cnt     <= '0;
          end
          ST_PLAY: begin
            r_state   <= ST_PAUSE;
            r_playing <= 1'b0;
            r_paused  <= 1'b1;
          end
          default: begin
            r_state   <= ST_PLAY;
            r_playing <= 1'b1;
            r_paused  <= 1'b0;
          end
        endcase
      end else if (r_state == ST_PLAY) begin
        if (w_term) begin
          r_cnt  <= '0;
          r_tick <= 1'b1;
          if (r_addr != LAST) begin
            r_addr <= r_addr + ADDR_W'(1);
          end else begin
            r_addr <= '0;
            r_done <= 1'b1;
            if (!r_loop) begin
              r_state   <= ST_STOP;
              r_playing <= 1'b0;
            end
          end
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign beat_addr  = r_addr;
  assign beat_tick  = r_tick;
  assign playing    = r_playing;
  assign paused     = r_paused;
  assign speed_fast = r_fast;
  assign loop_en    = r_loop;
  assign song_done  = r_done;
endmodule

// File: tb/tb_music_sequencer.sv
// Scoreboard bench for music_sequencer: a beat-position model predicts every
// cycle's outputs; a monitor pops and compares them after each rising edge.
module tb_music_sequencer;
  localparam int AW = 2, SL = 4, ND = 8, FD = 4;
  localparam logic [8:0] K_Z = 9'h01A, K_X = 9'h022, K_P = 9'h04D,
                         K_S = 9'h01B, K_L = 9'h04B, K_U = 9'h01C;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [511:0]  key_down = '0;
  logic [8:0]    last_change = '0;
  logic          key_valid = 1'b0;
  logic [AW-1:0] beat_addr;
  logic          beat_tick, playing, paused, speed_fast, loop_en, song_done;

  music_sequencer #(.ADDR_W(AW), .SONG_LEN(SL), .NORMAL_DIV(ND), .FAST_DIV(FD)) dut (
    .clk(clk), .rst(rst), .key_down(key_down), .last_change(last_change),
    .key_valid(key_valid), .beat_addr(beat_addr), .beat_tick(beat_tick),
    .playing(playing), .paused(paused), .speed_fast(speed_fast),
    .loop_en(loop_en), .song_done(song_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic tick, play, pause, fast, loop, done;
  } exp_t;

  exp_t sb_q[$];
  int errors = 0, checks = 0, cyc = 0;

  // Model: 0 = stopped, 1 = playing, 2 = paused; pos = beat, elapsed = cycles into beat
  int m_state = 0, m_pos = 0, m_elapsed = 0;
  bit m_fast = 0, m_loop = 0;

  task automatic model_reset();
    m_state = 0; m_pos = 0; m_elapsed = 0; m_fast = 0; m_loop = 0;
  endtask

  task automatic step(input bit valid, input bit down, input logic [8:0] code);
    bit press, tick, done;
    int div;
    exp_t e;
    @(negedge clk);
    for (int w = 0; w < 16; w++) key_down[w*32 +: 32] = $urandom;
    key_down[code] = down;
    last_change    = code;
    key_valid      = valid;
    press = valid && down;
    tick = 0; done = 0;
    div = m_fast ? FD : ND;
    if (press && code == K_S) begin
      m_state = 0; m_pos = 0; m_elapsed = 0;
    end else if (press && code == K_P) begin
      if (m_state == 0) begin m_state = 1; m_elapsed = 0; end
      else if (m_state == 1) m_state = 2;
      else m_state = 1;
    end else if (m_state == 1) begin
      if (m_elapsed + 1 >= div) begin
        m_elapsed = 0;
        tick = 1;
        m_pos = (m_pos + 1) % SL;
        if (m_pos == 0) begin
          done = 1;
          if (!m_loop) m_state = 0;
        end
      end else m_elapsed++;
    end
    if (press && code == K_Z) m_fast = 0;
    if (press && code == K_X) m_fast = 1;
    if (press && code == K_L) m_loop = !m_loop;
    e.addr = AW'(m_pos); e.tick = tick; e.play = (m_state == 1);
    e.pause = (m_state == 2); e.fast = m_fast; e.loop = m_loop; e.done = done;
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'($urandom_range(0, 1)), 9'($urandom));
  endtask

  task automatic press(input logic [8:0] code);
    step(1'b1, 1'b1, code);
  endtask

  task automatic check_reset_vals(input string name);
    checks++;
    if ({beat_addr, beat_tick, playing, paused, speed_fast, loop_en, song_done} !== '0) begin
      errors++;
      $display("FAIL %s: outputs got addr=%0d tick=%0b play=%0b pause=%0b fast=%0b loop=%0b done=%0b, want all 0",
               name, beat_addr, beat_tick, playing, paused, speed_fast, loop_en, song_done);
    end
  endtask

  // Reset pulse entirely between edges; outputs must drop before the next edge
  task automatic async_reset(input string name);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_vals(name);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic wait_elapsed(input int target, input string name);
    int i;
    i = 0;
    while (!(m_state == 1 && m_elapsed == target) && i < 64) begin
      idle(1);
      i++;
    end
    checks++;
    if (!(m_state == 1 && m_elapsed == target)) begin
      errors++;
      $display("FAIL %s: beat position %0d not reached (got %0d, state %0d)",
               name, target, m_elapsed, m_state);
    end
  endtask

  always @(posedge clk) begin
    exp_t e, g;
    #1;
    cyc++;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      g = {beat_addr, beat_tick, playing, paused, speed_fast, loop_en, song_done};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL cyc%0d: got addr=%0d tick=%0b play=%0b pause=%0b fast=%0b loop=%0b done=%0b, want addr=%0d tick=%0b play=%0b pause=%0b fast=%0b loop=%0b done=%0b",
                 cyc, g.addr, g.tick, g.play, g.pause, g.fast, g.loop, g.done,
                 e.addr, e.tick, e.play, e.pause, e.fast, e.loop, e.done);
      end
    end
  end

  initial begin
    logic [8:0] codes [6];
    codes[0] = K_Z; codes[1] = K_X; codes[2] = K_P;
    codes[3] = K_S; codes[4] = K_L; codes[5] = K_U;
    model_reset();
    #12 check_reset_vals("reset_held");
    @(negedge clk);
    rst = 1'b0;
    #1 check_reset_vals("reset_released");

    // Play once through without loop: 1,2,3,0 then stop
    idle(3);
    press(K_P);
    idle(40);

    // Loop mode keeps playing across the wrap
    press(K_L);
    press(K_P);
    idle(45);

    // Pause at cnt=5 for 20 cycles, resume
    wait_elapsed(5, "pause_pos");
    press(K_P);
    idle(20);
    press(K_P);
    idle(12);

    // Normal->fast at cnt=6 ticks on the next edge, then every 4; Z restores 8
    wait_elapsed(0, "fast_align");
    wait_elapsed(6, "fast_pos");
    press(K_X);
    idle(14);
    press(K_Z);
    idle(20);

    // S on the terminal edge: no tick, stop
    wait_elapsed(ND - 1, "stop_term");
    press(K_S);
    idle(3);
    // P on the terminal edge: no tick, pause with address held
    press(K_P);
    idle(ND + 3);
    wait_elapsed(ND - 1, "pause_term");
    press(K_P);
    idle(6);
    press(K_P);
    idle(5);

    // Break events and an unknown code change nothing
    step(1'b1, 1'b0, K_P);
    step(1'b1, 1'b0, K_S);
    step(1'b1, 1'b0, K_X);
    press(K_U);
    idle(6);

    // Asynchronous reset mid-beat
    wait_elapsed(3, "rst_pos");
    async_reset("reset_mid_beat");
    idle(4);

    // Randomized command mix
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) async_reset("reset_random");
      if ($urandom_range(0, 9) < 2)
        step(1'b1, ($urandom_range(0, 4) != 0), codes[$urandom_range(0, 5)]);
      else
        idle(1);
    end

    idle(2);
    @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses left, want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/music_sequencer.md
# music_sequencer

Playback scheduler for the song datapath. It decodes keyboard commands (play/pause, stop, speed, loop), runs a STOP/PLAY/PAUSE state machine, and advances the music ROM beat address at a tempo set by a divisor counter. It replaces divided-clock tempo selection: the whole design stays on `clk`, and downstream note/tone logic consumes `beat_addr` qualified by `beat_tick`.

## Interface
- `ADDR_W`, default 9: beat address width.
- `SONG_LEN`, default 512: number of beats in the song; must satisfy 2 ≤ SONG_LEN ≤ 2^ADDR_W.
- `NORMAL_DIV`, default 4194304: clk cycles per beat at normal speed.
- `FAST_DIV`, default 2097152: clk cycles per beat at fast speed; must satisfy 2 ≤ FAST_DIV ≤ NORMAL_DIV.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `key_down`  in  512  level map of currently held keys, indexed by scan code.
- `last_change`  in  9  scan code of the most recent make/break.
- `key_valid`  in  1  one-cycle pulse per make/break event.
- `beat_addr`  out  ADDR_W  current beat index into the music ROM.
- `beat_tick`  out  1  one-cycle pulse in the cycle `beat_addr` takes a new advanced value.
- `playing`  out  1  state == PLAY.
- `paused`  out  1  state == PAUSE.
- `speed_fast`  out  1  1 = FAST_DIV in use.
- `loop_en`  out  1  loop mode enabled.
- `song_done`  out  1  one-cycle pulse when the last beat completes.

## Operation
- Press event: `key_valid && key_down[last_change]`. Break events are ignored.
- Command codes:
  - 9'h01A Z: speed normal.
  - 9'h022 X: speed fast.
  - 9'h04D P: play/pause toggle.
  - 9'h01B S: stop.
  - 9'h04B L: loop toggle.
  - Any other code: no effect.
- Z, X and L are honored in every state.
- State machine:
  - STOP → PLAY on P; counter cleared.
  - PLAY → PAUSE on P; counter and address held.
  - PAUSE → PLAY on P; counter resumes from its held value.
  - Any state → STOP on S; `beat_addr` = 0, counter = 0.
- Beat counter `cnt`, width $clog2(NORMAL_DIV):
  - Increments every cycle in PLAY.
  - Terminal condition: `cnt >= div-1`, where `div` is selected by the current `speed_fast` register.
  - On terminal: cnt ← 0; beat_tick ← 1.
  - If addr ≠ SONG_LEN-1: addr ← addr+1.
  - If addr = SONG_LEN-1 with loop_en = 1: addr ← 0, song_done ← 1, stay in PLAY.
  - If addr = SONG_LEN-1 with loop_en = 0: addr ← 0, song_done ← 1, state ← STOP.
- The `>=` compare guarantees that switching normal→fast mid-beat with cnt ≥ FAST_DIV-1 ticks on the next edge; there is no lockup or wrap through 2^N.
- Speed changes never clear `cnt`.
- Priority on a single edge: S > P > beat terminal.
  - A P or S press on the terminal edge suppresses the tick, and `cnt` holds (P) or clears (S).
- Only one command can arrive per cycle, since `last_change` is a single code.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- Reset values: state STOP, `beat_addr` 0, `cnt` 0, `beat_tick` 0, `playing` 0, `paused` 0, `speed_fast` 0, `loop_en` 0, `song_done` 0.
- A command sampled at edge k is reflected in the outputs after edge k.
- A speed change at edge k applies to the terminal compare from edge k+1.
- From P in STOP at edge k:
  - `cnt` = 0 after edge k.
  - The first `beat_tick` with `beat_addr` = 1 appears after edge k+div.
  - Subsequent ticks occur every div cycles.
- `beat_tick` and `song_done` are high for exactly one cycle.
- `song_done` is coincident with the `beat_tick` that wraps `beat_addr` to 0.
- Reset mid-playback: immediate asynchronous return to the reset values. Any key event in progress is lost.

## Test plan
Bench parameters: NORMAL_DIV=8, FAST_DIV=4, SONG_LEN=4, ADDR_W=2.
- Reset, then P press → `playing`=1 next cycle; ticks every 8 cycles; `beat_addr` sequence 1, 2, 3, 0; `song_done` pulse on the 4th tick; then `playing`=0 with STOP.
- L press, then P → the 4th tick wraps `beat_addr` to 0 with `song_done`=1 and `playing` stays 1; playback continues 1, 2, …
- P at cnt=5, wait 20 cycles, P again → `paused`=1 throughout with `beat_addr` unchanged; the next tick comes 3 cycles after resume.
- X press at cnt=6 while playing normal → `speed_fast`=1; tick on the following cycle; then ticks every 4 cycles. Z restores 8-cycle ticks.
- S on the terminal edge, and separately P on the terminal edge → no `beat_tick`. S gives `beat_addr`=0 and STOP; P gives PAUSE with `beat_addr` unchanged.
- Break events for P, S, X (key_down bit = 0) and unknown code 9'h01C → no state change. Async `rst` mid-beat → every output at its reset value before the next edge.
